// File: rtl/mul_ecp_pipe_if.sv
// Handshake and status bus of the multiplier exception pipeline.
// The master drives the operand/status inputs and out_ready; the slave is the pipeline.
interface mul_ecp_pipe_if #(
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [LANES-1:0]   lane_en;
  logic [LANES-1:0]   is_inf_nan;
  logic [LANES-1:0]   r_is_nan;
  logic [LANES-1:0]   a_is_n0;
  logic [LANES-1:0]   b_is_n0;
  logic [LANES-1:0]   a_is_nor;
  logic [LANES-1:0]   b_is_nor;
  logic [LANES-1:0]   status_nv;
  logic [LANES-1:0]   dz_in;
  logic [LANES-1:0]   overflow;
  logic [LANES-1:0]   underflow;
  logic [LANES-1:0]   inexact_rnd;
  logic [LANES-1:0]   inexact_sft;
  logic               out_valid;
  logic               out_ready;
  logic [5*LANES-1:0] status_lane;
  logic [4:0]         status_or;

  modport master (
    output in_valid, lane_en, is_inf_nan, r_is_nan, a_is_n0, b_is_n0,
    output a_is_nor, b_is_nor, status_nv, dz_in, overflow, underflow,
    output inexact_rnd, inexact_sft, out_ready,
    input  in_ready, out_valid, status_lane, status_or
  );

  modport slave (
    input  in_valid, lane_en, is_inf_nan, r_is_nan, a_is_n0, b_is_n0,
    input  a_is_nor, b_is_nor, status_nv, dz_in, overflow, underflow,
    input  inexact_rnd, inexact_sft, out_ready,
    output in_ready, out_valid, status_lane, status_or
  );
endinterface

// File: rtl/mul_ecp_pipe.sv
// Pipelined per-lane IEEE-754 status flag generator {NV,DZ,OF,UF,NX} with
// bubble-collapsing valid/ready stages, sticky fflags and a saturating event counter.
module mul_ecp_pipe #(
  parameter int LANES = 4,
  parameter int DEPTH = 1,
  parameter int DZ_EN = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  mul_ecp_pipe_if.slave    bus,
  input  logic             flags_clr,
  output logic [4:0]       fflags,
  output logic [CNT_W-1:0] exc_cnt
);

  localparam int SW = 5 * LANES;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SW-1:0]             stat_in;
  logic [DEPTH-1:0]          v_q, v_d;
  logic [DEPTH-1:0][SW-1:0]  data_q, data_d;
  logic [DEPTH-1:0]          ld;
  logic [4:0]                sor;
  logic                      xfer;
  logic [4:0]                fflags_q, fflags_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  // Per-lane flag evaluation; only these bits travel down the pipe.
  always_comb begin
    stat_in = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.lane_en[i]) begin
        stat_in[5*i+4] = bus.status_nv[i];
        stat_in[5*i+3] = (DZ_EN != 0) ? bus.dz_in[i] : 1'b0;
        stat_in[5*i+2] = bus.overflow[i] & ~bus.is_inf_nan[i];
        stat_in[5*i+1] = bus.underflow[i] & bus.a_is_n0[i] & bus.b_is_n0[i];
        stat_in[5*i+0] = ((bus.inexact_rnd[i] | bus.inexact_sft[i]) & ~bus.r_is_nan[i])
                       | (bus.a_is_nor[i] & bus.b_is_nor[i] & bus.overflow[i]);
      end else begin
        stat_in[5*i +: 5] = 5'b00000;
      end
    end
  end

  // A stage may load if it is empty or everything downstream of it can move.
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    ld    = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      ld[s] = ~v_q[s] | chain;
      chain = ld[s];
    end
  end

  // Stage next-state: data only overwritten when a valid beat arrives.
  always_comb begin
    v_d       = v_q;
    data_d    = data_q;
    v_d[0]    = ld[0] ? bus.in_valid : v_q[0];
    data_d[0] = (ld[0] & bus.in_valid) ? stat_in : data_q[0];
    for (int s = 1; s < DEPTH; s++) begin
      v_d[s]    = ld[s] ? v_q[s-1] : v_q[s];
      data_d[s] = (ld[s] & v_q[s-1]) ? data_q[s-1] : data_q[s];
    end
  end

  // Lane OR of the output register.
  always_comb begin
    sor = 5'b00000;
    for (int i = 0; i < LANES; i++) begin
      sor = sor | data_q[DEPTH-1][5*i +: 5];
    end
  end

  assign xfer = v_q[DEPTH-1] & bus.out_ready;

  // Sticky flags and saturating counter; a clear coinciding with a transfer keeps that beat.
  always_comb begin
    fflags_d = fflags_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      if (flags_clr) begin
        fflags_d = sor;
        cnt_d    = (sor != 5'b00000) ? CNT_ONE : '0;
      end else begin
        fflags_d = fflags_q | sor;
        cnt_d    = ((sor != 5'b00000) && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
      end
    end else if (flags_clr) begin
      fflags_d = 5'b00000;
      cnt_d    = '0;
    end else begin
      fflags_d = fflags_q;
      cnt_d    = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      data_q   <= '0;
      fflags_q <= 5'b00000;
      cnt_q    <= '0;
    end else begin
      v_q      <= v_d;
      data_q   <= data_d;
      fflags_q <= fflags_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready    = ld[0];
  assign bus.out_valid   = v_q[DEPTH-1];
  assign bus.status_lane = data_q[DEPTH-1];
  assign bus.status_or   = sor;
  assign fflags          = fflags_q;
  assign exc_cnt         = cnt_q;

endmodule

// File: tb/tb_mul_ecp_pipe.sv
// Bench for mul_ecp_pipe: two instances (DZ_EN=0/CNT_W=16 and DZ_EN=1/CNT_W=2, both DEPTH=2)
// share one stimulus stream and are checked against a queue-based timing/flag model.
module tb_mul_ecp_pipe;
  localparam int LANES = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [3:0] lane_en, inf, nan, an0, bn0, anor, bnor, nv, dz, ovf, udf, rnd, sft;
  } in_t;

  typedef struct {
    in_t        x;
    logic [19:0] exp_a;
    logic [4:0]  exp_or_b;
  } vec_t;

  typedef struct {
    int          t;
    logic [19:0] sa;
    logic [19:0] sb;
  } beat_t;

  logic clk = 1'b0;
  logic rst, flags_clr, in_valid, out_ready;
  in_t  x;
  logic [4:0]  fflags_a, fflags_b;
  logic [15:0] exc_a;
  logic [1:0]  exc_b;

  mul_ecp_pipe_if #(.LANES(LANES)) ifa ();
  mul_ecp_pipe_if #(.LANES(LANES)) ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;
  assign ifa.lane_en = x.lane_en;  assign ifb.lane_en = x.lane_en;
  assign ifa.is_inf_nan = x.inf;   assign ifb.is_inf_nan = x.inf;
  assign ifa.r_is_nan = x.nan;     assign ifb.r_is_nan = x.nan;
  assign ifa.a_is_n0 = x.an0;      assign ifb.a_is_n0 = x.an0;
  assign ifa.b_is_n0 = x.bn0;      assign ifb.b_is_n0 = x.bn0;
  assign ifa.a_is_nor = x.anor;    assign ifb.a_is_nor = x.anor;
  assign ifa.b_is_nor = x.bnor;    assign ifb.b_is_nor = x.bnor;
  assign ifa.status_nv = x.nv;     assign ifb.status_nv = x.nv;
  assign ifa.dz_in = x.dz;         assign ifb.dz_in = x.dz;
  assign ifa.overflow = x.ovf;     assign ifb.overflow = x.ovf;
  assign ifa.underflow = x.udf;    assign ifb.underflow = x.udf;
  assign ifa.inexact_rnd = x.rnd;  assign ifb.inexact_rnd = x.rnd;
  assign ifa.inexact_sft = x.sft;  assign ifb.inexact_sft = x.sft;

  mul_ecp_pipe #(.LANES(LANES), .DEPTH(DEPTH), .DZ_EN(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .flags_clr(flags_clr), .fflags(fflags_a), .exc_cnt(exc_a)
  );
  mul_ecp_pipe #(.LANES(LANES), .DEPTH(DEPTH), .DZ_EN(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .flags_clr(flags_clr), .fflags(fflags_b), .exc_cnt(exc_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  beat_t q[$];
  logic [4:0] m_f_a, m_f_b;
  int m_c_a, m_c_b, cyc;
  bit last_acc;
  int n_dut_out;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [19:0] exp_status(in_t v, bit dz_en);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (v.lane_en[i]) begin
        r[5*i+4] = v.nv[i];
        r[5*i+3] = dz_en & v.dz[i];
        r[5*i+2] = v.ovf[i] & ~v.inf[i];
        r[5*i+1] = v.udf[i] & v.an0[i] & v.bn0[i];
        r[5*i+0] = ((v.rnd[i] | v.sft[i]) & ~v.nan[i]) | (v.anor[i] & v.bnor[i] & v.ovf[i]);
      end
    end
    return r;
  endfunction

  function automatic logic [4:0] or5(logic [19:0] s);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r = r | s[5*i +: 5];
    return r;
  endfunction

  function automatic bit model_ov();
    if (q.size() == 0) return 1'b0;
    return (cyc >= q[0].t + DEPTH);
  endfunction

  task automatic check_outputs();
    bit ov, ir;
    ov = model_ov();
    ir = (q.size() < DEPTH) || out_ready;
    chk("in_ready_a", ifa.in_ready, ir);
    chk("in_ready_b", ifb.in_ready, ir);
    chk("out_valid_a", ifa.out_valid, ov);
    chk("out_valid_b", ifb.out_valid, ov);
    if (ov) begin
      chk("status_lane_a", ifa.status_lane, q[0].sa);
      chk("status_or_a", ifa.status_or, or5(q[0].sa));
      chk("status_lane_b", ifb.status_lane, q[0].sb);
      chk("status_or_b", ifb.status_or, or5(q[0].sb));
    end
    chk("fflags_a", fflags_a, m_f_a);
    chk("fflags_b", fflags_b, m_f_b);
    chk("exc_cnt_a", exc_a, m_c_a);
    chk("exc_cnt_b", exc_b, m_c_b);
  endtask

  task automatic step();
    bit ir, ix, ox;
    beat_t b;
    logic [4:0] sa_or, sb_or;
    ir = (q.size() < DEPTH) || out_ready;
    ix = in_valid && ir;
    ox = model_ov() && out_ready;
    b.t = cyc;
    b.sa = exp_status(x, 1'b0);
    b.sb = exp_status(x, 1'b1);
    last_acc = ix;
    if (ifa.out_valid && out_ready && !rst) n_dut_out++;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_f_a = '0; m_f_b = '0; m_c_a = 0; m_c_b = 0;
    end else begin
      if (ox) begin
        sa_or = or5(q[0].sa);
        sb_or = or5(q[0].sb);
        if (flags_clr) begin
          m_f_a = sa_or; m_c_a = (sa_or != 0) ? 1 : 0;
          m_f_b = sb_or; m_c_b = (sb_or != 0) ? 1 : 0;
        end else begin
          m_f_a = m_f_a | sa_or;
          m_f_b = m_f_b | sb_or;
          if (sa_or != 0 && m_c_a < 65535) m_c_a++;
          if (sb_or != 0 && m_c_b < 3) m_c_b++;
        end
        void'(q.pop_front());
      end else if (flags_clr) begin
        m_f_a = '0; m_f_b = '0; m_c_a = 0; m_c_b = 0;
      end
      if (ix) q.push_back(b);
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  vec_t tbl [6];

  initial begin
    logic [63:0] r64;
    bit saw_drop;
    int sent;

    rst = 1'b1; flags_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    m_f_a = '0; m_f_b = '0; m_c_a = 0; m_c_b = 0; cyc = 0; n_dut_out = 0;

    tbl[0].x = '0; tbl[0].x.lane_en = 4'hF; tbl[0].x.ovf = 4'h1; tbl[0].x.anor = 4'h1; tbl[0].x.bnor = 4'h1;
    tbl[0].exp_a = 20'h00005; tbl[0].exp_or_b = 5'b00101;
    tbl[1].x = '0; tbl[1].x.lane_en = 4'h7; tbl[1].x.inf = 4'hA; tbl[1].x.nan = 4'hC;
    tbl[1].x.anor = 4'hA; tbl[1].x.bnor = 4'hA; tbl[1].x.ovf = 4'hA; tbl[1].x.rnd = 4'hC;
    tbl[1].x.an0 = 4'h8; tbl[1].x.bn0 = 4'h8; tbl[1].x.nv = 4'h8; tbl[1].x.dz = 4'hF;
    tbl[1].x.udf = 4'h8; tbl[1].x.sft = 4'h8;
    tbl[1].exp_a = 20'h00020; tbl[1].exp_or_b = 5'b01001;
    tbl[2].x = '0; tbl[2].x.lane_en = 4'hF; tbl[2].x.dz = 4'h1;
    tbl[2].exp_a = 20'h00000; tbl[2].exp_or_b = 5'b01000;
    tbl[3].x = '0; tbl[3].x.lane_en = 4'hF; tbl[3].x.udf = 4'h5; tbl[3].x.an0 = 4'h5; tbl[3].x.bn0 = 4'h4;
    tbl[3].exp_a = 20'h00800; tbl[3].exp_or_b = 5'b00010;
    tbl[4].x = '0; tbl[4].x.lane_en = 4'hF; tbl[4].x.nv = 4'h8; tbl[4].x.sft = 4'h1;
    tbl[4].exp_a = 20'h80001; tbl[4].exp_or_b = 5'b10001;
    tbl[5].x = '0; tbl[5].x.lane_en = 4'hF;
    tbl[5].exp_a = 20'h00000; tbl[5].exp_or_b = 5'b00000;

    step(); step();
    rst = 1'b0;
    chk("rst_status_lane", ifa.status_lane, 20'h00000);
    chk("rst_status_or", ifa.status_or, 5'b00000);
    step();

    // Directed table: one beat each, visible exactly DEPTH cycles after presentation.
    for (int k = 0; k < 6; k++) begin
      x = tbl[k].x; in_valid = 1'b1;
      step();
      chk("tbl_not_early", ifa.out_valid, 1'b0);
      in_valid = 1'b0; x = '0;
      step();
      chk("tbl_valid", ifa.out_valid, 1'b1);
      chk("tbl_lane_a", ifa.status_lane, tbl[k].exp_a);
      chk("tbl_or_b", ifb.status_or, tbl[k].exp_or_b);
      step();
      if (k == 0) begin
        chk("tbl0_fflags", fflags_a, 5'b00101);
        chk("tbl0_exc_cnt", exc_a, 16'd1);
      end
    end

    // Back-pressure: 6 distinct beats, 4 stalled cycles, then toggling out_ready.
    rst = 1'b1; step(); rst = 1'b0;
    n_dut_out = 0; saw_drop = 1'b0; sent = 0;
    r64 = {$urandom(), $urandom()}; x = r64[51:0]; x.lane_en = 4'hF; x.nv = 4'(sent);
    for (int k = 0; k < 40; k++) begin
      out_ready = (k < 4) ? 1'b0 : k[0];
      in_valid = (sent < 6);
      step();
      if (!ifa.in_ready) saw_drop = 1'b1;
      if (last_acc) begin
        sent++;
        r64 = {$urandom(), $urandom()}; x = r64[51:0]; x.lane_en = 4'hF; x.nv = 4'(sent);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("bp_inready_drop", saw_drop, 1'b1);
    chk("bp_beats_out", n_dut_out, 6);

    // flags_clr coinciding with a transfer.
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    x = '0; x.lane_en = 4'hF; x.udf = 4'h1; x.an0 = 4'h1; x.bn0 = 4'h1; x.rnd = 4'h1;
    step();
    x = '0; x.lane_en = 4'hF; x.nv = 4'h1;
    step();
    in_valid = 1'b0; x = '0; out_ready = 1'b1;
    step();
    chk("clr_pre_fflags", fflags_a, 5'b00011);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    chk("clr_xfer_fflags", fflags_a, 5'b10000);
    chk("clr_xfer_cnt", exc_a, 16'd1);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    chk("clr_idle_fflags", fflags_a, 5'b00000);

    // Counter saturation on the CNT_W=2 instance.
    rst = 1'b1; step(); rst = 1'b0;
    x = '0; x.lane_en = 4'hF; x.ovf = 4'h1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    in_valid = 1'b0; x = '0;
    for (int k = 0; k < 3; k++) step();
    chk("sat_cnt_b", exc_b, 2'd3);
    chk("sat_cnt_a", exc_a, 16'd5);

    // Reset with two beats in flight and a transfer pending.
    out_ready = 1'b0; in_valid = 1'b1;
    x = '0; x.lane_en = 4'hF; x.nv = 4'h3;
    step(); step();
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", ifa.out_valid, 1'b0);
    chk("rst_mid_fflags", fflags_a, 5'b00000);
    chk("rst_mid_cnt", exc_a, 16'd0);
    chk("rst_mid_ready", ifa.in_ready, 1'b1);
    for (int k = 0; k < 4; k++) step();

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flags_clr = ($urandom_range(15) == 0);
      r64 = {$urandom(), $urandom()};
      x = r64[51:0];
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("drain_empty", ifa.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_ecp_pipe.md
Name: mul_ecp_pipe

Overview:
- Parametrised, pipelined successor to the multiplier exception/status generator.
- Computes IEEE-754 status flags {NV,DZ,OF,UF,NX} for LANES parallel lanes, with a valid/ready pipeline of DEPTH stages.
- Keeps a sticky accumulated fflags register and a saturating exception-event counter.
- Sits between the rounding stage of a SIMD multiply (or divide, DZ_EN=1) datapath and the CSR/fflags writeback.

Parameters:
LANES, 4, number of parallel lanes (>=1)
DEPTH, 1, pipeline register stages from input to output (>=1)
DZ_EN, 0, 1 = honour dz_in (divider mode); 0 = DZ forced to 0
CNT_W, 16, width of exception event counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  pipeline can accept a beat
lane_en  in  LANES  per-lane enable; disabled lanes produce all-zero status
is_inf_nan  in  LANES  result forced to Inf/NaN by special operands
r_is_nan  in  LANES  result is NaN
a_is_n0, b_is_n0  in  LANES each  operand non-zero
a_is_nor, b_is_nor  in  LANES each  operand normal
status_nv  in  LANES  invalid-operation detected upstream
dz_in  in  LANES  divide-by-zero detected upstream (ignored if DZ_EN=0)
overflow, underflow  in  LANES each  raw OF/UF from rounder
inexact_rnd, inexact_sft  in  LANES each  rounding / shift-out inexact
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
status_lane  out  5*LANES  lane i at [5i+4:5i] = {NV,DZ,OF,UF,NX}
status_or  out  5  bitwise OR of status_lane over all lanes
flags_clr  in  1  clear sticky flags and counter
fflags  out  5  sticky OR of status_or over all completed transfers
exc_cnt  out  CNT_W  saturating count of transfers with status_or != 0

Behaviour:
- Per-lane function, computed at input from the input signals. All terms are zero when lane_en[i]=0.
  - NV = status_nv.
  - DZ = DZ_EN ? dz_in : 0.
  - OF = overflow & ~is_inf_nan.
  - UF = underflow & a_is_n0 & b_is_n0.
  - NX = ((inexact_rnd | inexact_sft) & ~r_is_nan) | (a_is_nor & b_is_nor & overflow).
- Only the 5*LANES status bits are stored in the pipe; raw inputs are not.
- Pipeline: stages s=0..DEPTH-1, each with valid v[s] and a data register.
  - Stage s loads when ~v[s] | advance[s+1]; stage DEPTH-1 advances on out_ready.
  - in_ready = ~v[0] | advance[1] (bubble-collapsing).
  - A beat transfers at input when in_valid & in_ready.
  - Stage valid clears when its data moves on and no new data arrives.
- Latency: exactly DEPTH cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Ordering: data order is preserved; no beat is dropped or duplicated under any out_ready pattern.
- Outputs: out_valid = v[DEPTH-1]. status_lane and status_or come from the last stage register and must hold stable while out_valid & ~out_ready.
- Output transfer (out_valid & out_ready):
  - fflags <= fflags | status_or.
  - exc_cnt increments when status_or != 0, saturating at all-ones.
- flags_clr:
  - With no transfer in the same cycle: fflags <= 0, exc_cnt <= 0.
  - Same cycle as a transfer: fflags <= status_or; exc_cnt <= (status_or != 0).
  - flags_clr does not affect pipeline contents.
- Reset: all v[s]=0, data registers 0. After reset: out_valid=0, status_lane=0, status_or=0, fflags=0, exc_cnt=0, in_ready=1.
- Reset mid-operation discards all in-flight beats with no fflags/exc_cnt update that cycle.
- in_valid low: no stage loads new data; bubbles propagate.

Test Plan:
- DEPTH=2, LANES=4, out_ready=1; one beat with lane0 overflow=1, is_inf_nan=0, a/b_is_nor=1 -> out_valid exactly 2 cycles later; status_lane[4:0]=5'b00101; status_or=5'b00101; fflags=5'b00101; exc_cnt=1.
- Masking and special cases:
  - lane1 overflow=1 with is_inf_nan=1 -> OF=0.
  - lane2 inexact_rnd=1 with r_is_nan=1, nor=0 -> NX=0.
  - lane3 all inputs set but lane_en[3]=0 -> status_lane[19:15]=0.
- DZ_EN=0 with dz_in=all ones -> DZ bit 0 everywhere. DZ_EN=1 with lane0 dz_in=1 -> status_or=5'b01000.
- Back-pressure: stream 6 distinct beats, hold out_ready=0 for 4 cycles, then toggle it -> in_ready drops once all DEPTH stages are full; outputs stay stable while stalled; all 6 beats emerge in order.
- flags_clr asserted in the same cycle as a transfer with status_or=5'b10000 while fflags=5'b00011 -> fflags=5'b10000, exc_cnt=1. CNT_W=2 with 5 flagged transfers -> exc_cnt saturates at 3.
- rst asserted with 2 beats in flight -> next cycle out_valid=0, fflags=0, exc_cnt=0, in_ready=1; no stale beat appears afterwards.
